microwire_eeprom_slave: RTL and testbench
=========================================

Name: microwire_eeprom_slave

Overview:
- Synchronous 93C46-style Microwire EEPROM slave front-end, sitting directly downstream of the bus-access bit-bang decoder. That decoder drives CS/SK/DI from CPU reads and samples DO back.
- Decodes start bit, opcode and address.
- Shifts read data out and write data in.
- Gates programming with a write-enable latch.
- Issues word-wide read/write requests to an external storage array, and emulates the device busy/ready status on DO.

Parameters:
- ADDR_W, 6, word address width; array depth is 2^ADDR_W.
- DATA_W, 16, word width.
- WRITE_CYCLES, 32, clk cycles of busy per programmed word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cs  in  1  chip select, asynchronous to clk.
- sk  in  1  serial clock, asynchronous to clk.
- di  in  1  serial data in, asynchronous to clk.
- dout  out  1  serial data out.
- dout_oe  out  1  dout drive enable.
- mem_addr  out  ADDR_W  array word address.
- mem_rd  out  1  one-cycle read strobe; mem_rdata is valid the following clk.
- mem_rdata  in  DATA_W  array read data.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  DATA_W  array write data.
- busy  out  1  programming in progress.
- wen  out  1  write-enable latch state.

Behaviour:
- Synchronisation: cs, sk and di each pass through 2 flops. The SK event is a synchronised rising edge. All protocol actions happen only on an SK event with synced cs=1.
- CS fall (synced cs 1->0) takes priority over a coincident SK event, and that SK event is ignored.
- Reset: state IDLE. dout=0, dout_oe=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, wen=0. Any in-flight command or programming is aborted, and no mem_wr is issued afterwards.
- IDLE:
  - DI=0 events are ignored.
  - A DI=1 event is the start bit, giving OPC, but only when busy=0; otherwise it is ignored.
- OPC: shifts 2 bits, giving ADDR.
- ADDR: shifts ADDR_W bits MSB first. On the last bit, dispatch by opcode:
  - 10 READ:
    - On the last-address SK event: dout=0 (dummy bit), dout_oe=1, and mem_rd pulses with the address.
    - Next clk: load the shift register from mem_rdata.
    - Each subsequent SK event drives the next bit, MSB first.
    - After DATA_W bits the address increments mod 2^ADDR_W. The next word is fetched and continues without a dummy bit.
  - 01 WRITE: goes to DATA and shifts DATA_W bits.
  - 11 ERASE: goes to DONE with wdata = all ones.
  - 00 extended, decoded on the top two address bits:
    - 11 EWEN: sets wen.
    - 00 EWDS: clears wen.
    - 10 ERAL: goes to DONE, all addresses, data all ones.
    - 01 WRAL: goes to DATA, then all addresses.
- DATA: after DATA_W bits, goes to DONE. Further SK events are ignored.
- Commit: on CS fall in DONE with wen=1, programming starts.
  - busy=1.
  - Single-word commands: one mem_wr pulse on the clk after CS fall, then busy held WRITE_CYCLES clks.
  - ERAL/WRAL: mem_wr issued for addresses 0..2^ADDR_W-1 in order, each pulse followed by WRITE_CYCLES busy clks.
  - With wen=0, DONE returns to IDLE with no write.
- CS fall in any other state returns to IDLE immediately: partial command discarded, dout_oe=0. EWEN/EWDS take effect on their last address bit.
- Status: while synced cs=1 in IDLE, dout_oe=1 and dout=~busy. With cs=0, dout_oe=0 except during READ, which drops dout_oe on CS fall.
- Reset mid-programming: busy clears at once and remaining ERAL/WRAL words are not written.

Test Plan:
- Reset, then WRITE addr 0x05 data 0xA5A5 without EWEN, then CS low -> no mem_wr, busy=0, wen=0.
- EWEN, then WRITE addr 0x05 data 0xA5A5, then CS low -> exactly one mem_wr, mem_addr=0x05, mem_wdata=0xA5A5. busy=1 for 32 clks. With CS high, dout=0 during busy, then 1.
- READ addr 0x3F, array returning data = {10'h0, addr} -> dummy 0, then 0x003F MSB first, then 0x0000 with no dummy (address wraps).
- EWEN then ERAL, then CS low -> 64 mem_wr pulses at addresses 0..63, all with 0xFFFF, each separated by 32 busy clks.
- EWEN, WRITE addr 0x10, CS dropped after 8 data bits -> no mem_wr, state IDLE. A following READ works normally.
- EWDS then ERASE addr 0x02 -> no mem_wr. A start bit issued during busy is ignored, and the status bit stays 0.

Source files
------------

// File: rtl/microwire_eeprom_slave.sv
// 93C46-style Microwire EEPROM slave front-end.
// Oversamples CS/SK/DI on clk, decodes start/opcode/address, shifts read
// data out and write data in, gates programming with a write-enable latch
// and emulates the busy/ready status bit on DO.
// SK is expected to be slow relative to clk (several clks per SK phase),
// so a read fetch always lands before the next SK event needs the data.
module microwire_eeprom_slave #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int WRITE_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sk,
    input  logic              di,
    output logic              dout,
    output logic              dout_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              wen
);
    localparam int CW = $clog2((DATA_W > ADDR_W) ? DATA_W : ADDR_W);
    localparam int WW = $clog2(WRITE_CYCLES + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_OPC, ST_ADDR, ST_READ, ST_DATA, ST_DONE} state_t;

    logic [2:0]        cs_q;
    logic [2:0]        sk_q;
    logic [1:0]        di_q;
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        opc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sh_q;
    logic              all_q, do_wr_q, load_q;
    logic              wen_q, busy_q;
    logic [WW-1:0]     wcnt_q;
    logic              dout_q, oe_q, mem_rd_q, mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              cs_s, di_s, sk_ev, cs_fall;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] sh_d;

    // Two-flop synchronisers; cs_q[2] and sk_q[2] hold the previous synced value
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= '0;
            sk_q <= '0;
            di_q <= '0;
        end else begin
            cs_q <= {cs_q[1:0], cs};
            sk_q <= {sk_q[1:0], sk};
            di_q <= {di_q[0], di};
        end
    end

    assign cs_s    = cs_q[1];
    assign di_s    = di_q[1];
    assign cs_fall = cs_q[2] & ~cs_q[1];
    assign sk_ev   = cs_s & sk_q[1] & ~sk_q[2];
    assign addr_d  = {addr_q[ADDR_W-2:0], di_s};
    assign sh_d    = {sh_q[DATA_W-2:0], di_s};

    // Protocol FSM, read fetch, programming engine and registered DO status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opc_q       <= '0;
            addr_q      <= '0;
            sh_q        <= '0;
            all_q       <= 1'b0;
            do_wr_q     <= 1'b0;
            load_q      <= 1'b0;
            wen_q       <= 1'b0;
            busy_q      <= 1'b0;
            wcnt_q      <= '0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            // rdata is valid the clk after the strobe; capture it then
            load_q   <= mem_rd_q;
            if (load_q)
                sh_q <= mem_rdata;

            // outside READ, DO only carries the ready bit while idle and selected
            if (state_q != ST_READ) begin
                oe_q   <= (state_q == ST_IDLE) & cs_s;
                dout_q <= (state_q == ST_IDLE) & cs_s & ~busy_q;
            end

            // programming timer; bulk commands step through every address
            if (busy_q) begin
                if (wcnt_q == WW'(WRITE_CYCLES - 1)) begin
                    wcnt_q <= '0;
                    if (all_q && (mem_addr_q != '1)) begin
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end

            if (cs_fall) begin
                // deselect always ends the transaction; DONE may commit
                state_q <= ST_IDLE;
                oe_q    <= 1'b0;
                dout_q  <= 1'b0;
                if (state_q == ST_DONE && do_wr_q && wen_q) begin
                    busy_q      <= 1'b1;
                    wcnt_q      <= '0;
                    mem_wr_q    <= 1'b1;
                    mem_addr_q  <= all_q ? '0 : addr_q;
                    mem_wdata_q <= sh_q;
                end
            end else if (sk_ev) begin
                case (state_q)
                    ST_IDLE: begin
                        if (di_s && !busy_q) begin
                            state_q <= ST_OPC;
                            cnt_q   <= '0;
                        end
                    end
                    ST_OPC: begin
                        opc_q <= {opc_q[0], di_s};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q <= ST_ADDR;
                            cnt_q   <= '0;
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(ADDR_W - 1)) begin
                            cnt_q   <= '0;
                            all_q   <= 1'b0;
                            do_wr_q <= 1'b0;
                            sh_q    <= '1;
                            state_q <= ST_DONE;
                            case (opc_q)
                                2'b10: begin
                                    state_q    <= ST_READ;
                                    dout_q     <= 1'b0;
                                    oe_q       <= 1'b1;
                                    mem_rd_q   <= 1'b1;
                                    mem_addr_q <= addr_d;
                                end
                                2'b01: state_q <= ST_DATA;
                                2'b11: do_wr_q <= 1'b1;
                                default: begin
                                    case (addr_d[ADDR_W-1 -: 2])
                                        2'b11: wen_q <= 1'b1;
                                        2'b00: wen_q <= 1'b0;
                                        2'b10: begin
                                            do_wr_q <= 1'b1;
                                            all_q   <= 1'b1;
                                        end
                                        default: begin
                                            all_q   <= 1'b1;
                                            state_q <= ST_DATA;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                    ST_READ: begin
                        dout_q <= sh_q[DATA_W-1];
                        sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            // sequential read: fetch the next word, no dummy bit
                            cnt_q      <= '0;
                            addr_q     <= addr_q + 1'b1;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= addr_q + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        sh_q  <= sh_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            state_q <= ST_DONE;
                            do_wr_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dout      = dout_q;
    assign dout_oe   = oe_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign wen       = wen_q;

endmodule

// File: tb/tb_microwire_eeprom_slave.sv
// Bench for microwire_eeprom_slave: command table, hand-written corner
// sequences and a randomized command stream against an array-level model.
module tb_microwire_eeprom_slave;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int WC = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0, sk = 1'b0, di = 1'b0;
    logic          dout, dout_oe, mem_rd, mem_wr, busy, wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem_wdata;

    always #5 clk = ~clk;

    microwire_eeprom_slave #(.ADDR_W(AW), .DATA_W(DW), .WRITE_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .cs(cs), .sk(sk), .di(di),
        .dout(dout), .dout_oe(dout_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .busy(busy), .wen(wen)
    );

    // storage array seen by the DUT, plus a log of every write strobe
    logic [DW-1:0] dut_mem [DEPTH] = '{default: '0};
    logic          rd_mode = 1'b0;
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q [$];
    int            cyc = 0;
    int            busy_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (mem_wr) begin
            dut_mem[mem_addr] <= mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (mem_rd) mem_rdata <= rd_mode ? {10'h0, mem_addr} : dut_mem[mem_addr];
    end

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_wen;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sk_bit(input logic b, output logic o);
        di = b;
        tick(2);
        sk = 1'b1;
        tick(3);
        sk = 1'b0;
        tick(3);
        o = dout;
    endtask

    task automatic send(input logic [31:0] v, input int n);
        logic o;
        for (int i = n - 1; i >= 0; i--) sk_bit(v[i], o);
    endtask

    task automatic cmd(input logic [1:0] opc, input logic [AW-1:0] a);
        send(32'd1, 1);
        send({30'd0, opc}, 2);
        send({26'd0, a}, AW);
    endtask

    task automatic cs_hi();
        cs = 1'b1;
        tick(4);
    endtask

    task automatic cs_lo();
        cs = 1'b0;
        di = 1'b0;
        tick(4);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            tick(1);
            n++;
        end
        chk("busy_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic read_word(output logic [DW-1:0] w);
        logic o;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            sk_bit(1'b0, o);
            w = {w[DW-2:0], o};
        end
    endtask

    function automatic logic needs_data(input logic [1:0] opc, input logic [AW-1:0] a);
        return (opc == 2'b01) || (opc == 2'b00 && a[AW-1 -: 2] == 2'b01);
    endfunction

    task automatic run_cmd(input logic [1:0] opc, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs_hi();
        cmd(opc, a);
        if (needs_data(opc, a)) send({16'd0, d}, DW);
        cs_lo();
        wait_idle();
    endtask

    // array-level effect of one complete command, returns expected write count
    task automatic model(input logic [1:0] opc, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int nwr);
        nwr = 0;
        case (opc)
            2'b01: if (ref_wen) begin ref_mem[a] = d; nwr = 1; end
            2'b11: if (ref_wen) begin ref_mem[a] = 16'hFFFF; nwr = 1; end
            2'b10: ;
            default: begin
                case (a[AW-1 -: 2])
                    2'b11: ref_wen = 1'b1;
                    2'b00: ref_wen = 1'b0;
                    2'b10: if (ref_wen) begin
                        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'hFFFF;
                        nwr = DEPTH;
                    end
                    default: if (ref_wen) begin
                        for (int i = 0; i < DEPTH; i++) ref_mem[i] = d;
                        nwr = DEPTH;
                    end
                endcase
            end
        endcase
    endtask

    typedef struct {
        logic [1:0]    opc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_wen;
        int            exp_nwr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [8];
        int            n0, n1, b0, nexp, bad, mism;
        logic [DW-1:0] w, w2, d;
        logic [AW-1:0] a, a1;
        logic [1:0]    opc;
        logic          o;
        int            op;

        tbl[0] = '{2'b01, 6'h05, 16'hA5A5, 1'b0, 0, 6'h00, 16'h0000}; // WRITE, wen=0
        tbl[1] = '{2'b00, 6'h30, 16'h0000, 1'b1, 0, 6'h00, 16'h0000}; // EWEN
        tbl[2] = '{2'b01, 6'h05, 16'hA5A5, 1'b1, 1, 6'h05, 16'hA5A5}; // WRITE
        tbl[3] = '{2'b11, 6'h02, 16'h0000, 1'b1, 1, 6'h02, 16'hFFFF}; // ERASE
        tbl[4] = '{2'b00, 6'h0A, 16'h0000, 1'b0, 0, 6'h00, 16'h0000}; // EWDS
        tbl[5] = '{2'b11, 6'h02, 16'h0000, 1'b0, 0, 6'h00, 16'h0000}; // ERASE, wen=0
        tbl[6] = '{2'b00, 6'h3C, 16'h0000, 1'b1, 0, 6'h00, 16'h0000}; // EWEN
        tbl[7] = '{2'b01, 6'h3F, 16'h1234, 1'b1, 1, 6'h3F, 16'h1234}; // WRITE top address

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_wen = 1'b0;

        // reset values
        rst = 1'b1;
        tick(4);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_oe", {31'd0, dout_oe}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_addr", {26'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        rst = 1'b0;
        tick(4);
        chk("idle_oe_cs0", {31'd0, dout_oe}, 32'd0);

        // command table
        foreach (tbl[i]) begin
            n0 = wr_addr_q.size();
            run_cmd(tbl[i].opc, tbl[i].addr, tbl[i].data);
            model(tbl[i].opc, tbl[i].addr, tbl[i].data, nexp);
            chk($sformatf("tbl%0d_wen", i), {31'd0, wen}, {31'd0, tbl[i].exp_wen});
            chk($sformatf("tbl%0d_nwr", i), wr_addr_q.size() - n0, tbl[i].exp_nwr);
            if (tbl[i].exp_nwr > 0 && wr_addr_q.size() > n0) begin
                chk($sformatf("tbl%0d_addr", i), {26'd0, wr_addr_q[n0]}, {26'd0, tbl[i].exp_addr});
                chk($sformatf("tbl%0d_data", i), {16'd0, wr_data_q[n0]}, {16'd0, tbl[i].exp_data});
            end
        end

        // write busy timing, status bit, start bit ignored while busy
        cs_hi();
        chk("status_ready_pre", {30'd0, dout_oe, dout}, 32'd3);
        cmd(2'b01, 6'h05);
        send(32'h5A5A, DW);
        n0 = wr_addr_q.size();
        b0 = busy_cyc;
        cs_lo();
        cs_hi();
        chk("status_busy", {30'd0, dout_oe, dout}, 32'd2);
        sk_bit(1'b1, o);
        di = 1'b0;
        chk("status_after_start", {30'd0, dout_oe, dout}, 32'd2);
        wait_idle();
        tick(3);
        chk("status_ready_post", {30'd0, dout_oe, dout}, 32'd3);
        chk("wr_busy_cycles", busy_cyc - b0, WC);
        chk("wr_nwr", wr_addr_q.size() - n0, 1);
        if (wr_addr_q.size() > n0) begin
            chk("wr_addr", {26'd0, wr_addr_q[n0]}, 32'h05);
            chk("wr_data", {16'd0, wr_data_q[n0]}, 32'h5A5A);
        end
        cs_lo();
        model(2'b01, 6'h05, 16'h5A5A, nexp);

        // sequential read across the top address
        rd_mode = 1'b1;
        cs_hi();
        cmd(2'b10, 6'h3F);
        chk("rd_dummy", {30'd0, dout_oe, dout}, 32'd2);
        read_word(w);
        chk("rd_word0", {16'd0, w}, 32'h003F);
        read_word(w);
        chk("rd_word1_wrap", {16'd0, w}, 32'h0000);
        cs_lo();
        chk("rd_oe_drop", {31'd0, dout_oe}, 32'd0);
        rd_mode = 1'b0;

        // ERAL: every address, in order, spaced by the write time
        cs_hi();
        cmd(2'b00, 6'h20);
        n0 = wr_addr_q.size();
        b0 = busy_cyc;
        cs_lo();
        wait_idle();
        model(2'b00, 6'h20, 16'h0000, nexp);
        chk("eral_nwr", wr_addr_q.size() - n0, nexp);
        bad = 0;
        if (wr_addr_q.size() - n0 == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr_q[n0 + i] != AW'(i) || wr_data_q[n0 + i] != 16'hFFFF) bad++;
                if (i > 0 && wr_cyc_q[n0 + i] - wr_cyc_q[n0 + i - 1] != WC) bad++;
            end
        end else bad = 1;
        chk("eral_sequence", bad, 0);
        chk("eral_busy_cycles", busy_cyc - b0, DEPTH * WC);

        // WRITE aborted after 8 data bits, then a normal read
        n0 = wr_addr_q.size();
        cs_hi();
        cmd(2'b01, 6'h10);
        send(32'hC3, 8);
        cs_lo();
        tick(40);
        chk("abort_nwr", wr_addr_q.size() - n0, 0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_oe", {31'd0, dout_oe}, 32'd0);
        cs_hi();
        chk("abort_idle_status", {30'd0, dout_oe, dout}, 32'd3);
        cmd(2'b10, 6'h10);
        read_word(w);
        cs_lo();
        chk("abort_read", {16'd0, w}, {16'd0, ref_mem[16]});

        // reset in the middle of ERAL stops the sequence
        cs_hi();
        cmd(2'b00, 6'h20);
        cs_lo();
        tick(100);
        rst = 1'b1;
        tick(2);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_wen", {31'd0, wen}, 32'd0);
        n1 = wr_addr_q.size();
        rst = 1'b0;
        tick(100);
        chk("rstmid_no_wr", wr_addr_q.size() - n1, 0);
        ref_wen = 1'b0;

        // randomized command stream against the array model
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 9);
            a  = AW'($urandom);
            d  = DW'($urandom);
            case (op)
                0, 1: begin opc = 2'b00; a = {2'b11, a[AW-3:0]}; end
                2:    begin opc = 2'b00; a = {2'b00, a[AW-3:0]}; end
                3, 4, 5: opc = 2'b01;
                6:    opc = 2'b11;
                7, 8: opc = 2'b10;
                default: begin opc = 2'b00; a = {2'b01, a[AW-3:0]}; end
            endcase
            if (opc == 2'b10) begin
                a1 = a + 1'b1;
                cs_hi();
                cmd(2'b10, a);
                read_word(w);
                read_word(w2);
                cs_lo();
                chk($sformatf("rnd%0d_rd0", it), {16'd0, w}, {16'd0, ref_mem[a]});
                chk($sformatf("rnd%0d_rd1", it), {16'd0, w2}, {16'd0, ref_mem[a1]});
            end else begin
                n0 = wr_addr_q.size();
                run_cmd(opc, a, d);
                tick(2);
                model(opc, a, d, nexp);
                chk($sformatf("rnd%0d_nwr", it), wr_addr_q.size() - n0, nexp);
                chk($sformatf("rnd%0d_wen", it), {31'd0, wen}, {31'd0, ref_wen});
                mism = 0;
                for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
                chk($sformatf("rnd%0d_image", it), mism, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
